// File: rtl/rdsched_pkg.sv
// Shared types and constants for the result/display scheduler.
package rdsched_pkg;

  localparam int unsigned DEF_ADDR_W = 4;
  localparam int unsigned DEF_DATA_W = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    READ  = 2'd2,
    WAIT  = 2'd3
  } state_e;

  localparam logic DIR_NEXT = 1'b0;
  localparam logic DIR_PREV = 1'b1;

endpackage

// File: rtl/result_display_scheduler_if.sv
// Single-port result RAM bus between the scheduler (master) and the RAM (slave).
interface result_display_scheduler_if
  import rdsched_pkg::*;
#(
  parameter int unsigned ADDR_W = DEF_ADDR_W,
  parameter int unsigned DATA_W = DEF_DATA_W
);
  logic              ram_en;
  logic              ram_we;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_din;
  logic [DATA_W-1:0] ram_dout;

  modport master (output ram_en, ram_we, ram_addr, ram_din, input ram_dout);
  modport slave  (input ram_en, ram_we, ram_addr, ram_din, output ram_dout);
endinterface

// File: rtl/result_display_scheduler_dwell_timer.sv
// Auto-scan dwell counter: registered tick once every DWELL_CYCLES enabled cycles.
module dwell_timer #(
  parameter int unsigned DWELL_CYCLES = 100000000
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clr,
  output logic tick
);
  localparam int unsigned CNT_W = (DWELL_CYCLES > 1) ? $clog2(DWELL_CYCLES) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(DWELL_CYCLES - 1);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt  <= '0;
      tick <= 1'b0;
    end else if (!en || clr) begin
      cnt  <= '0;
      tick <= 1'b0;
    end else if (cnt == LAST) begin
      cnt  <= '0;
      tick <= 1'b1;
    end else begin
      cnt  <= cnt + CNT_W'(1);
      tick <= 1'b0;
    end
  end
endmodule

// File: rtl/result_display_scheduler.sv
// Arbitrates result-RAM writes from the RSA core against browse/auto-scan reads
// and drives the display register from whichever access completes.
module result_display_scheduler
  import rdsched_pkg::*;
#(
  parameter int unsigned ADDR_W       = DEF_ADDR_W,
  parameter int unsigned DATA_W       = DEF_DATA_W,
  parameter int unsigned DWELL_CYCLES = 100000000
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      cal_done,
  input  logic [DATA_W-1:0]         cal_result,
  input  logic                      browse_next,
  input  logic                      browse_prev,
  input  logic                      auto_en,
  result_display_scheduler_if.master ram,
  output logic [DATA_W-1:0]         display,
  output logic [ADDR_W-1:0]         disp_addr,
  output logic [ADDR_W:0]           count,
  output logic                      busy
);
  localparam int unsigned DEPTH = 2**ADDR_W;
  localparam logic [ADDR_W:0] FULL = (ADDR_W+1)'(DEPTH);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] wr_ptr, wr_ptr_d, rd_ptr, rd_ptr_d, disp_addr_d, ram_addr_d;
  logic [ADDR_W:0]   count_d;
  logic [DATA_W-1:0] display_d, pend_data, pend_data_d, ram_din_d;
  logic              pend_wr, pend_wr_d, pend_rd, pend_rd_d, pend_dir, pend_dir_d;
  logic              ram_en_d, ram_we_d, busy_d;
  logic              rd_req, rd_dir, wr_start, scan_en, scan_clr, scan_tick;

  // Step within the stored window; with a full ring this reduces to modulo DEPTH.
  function automatic logic [ADDR_W-1:0] step_addr(input logic [ADDR_W-1:0] ptr,
                                                  input logic [ADDR_W:0]   cnt,
                                                  input logic              dir);
    logic [ADDR_W-1:0] last;
    last = ADDR_W'(cnt - (ADDR_W+1)'(1));
    if (dir == DIR_NEXT) step_addr = (ptr == last) ? '0 : ptr + ADDR_W'(1);
    else                 step_addr = (ptr == '0) ? last : ptr - ADDR_W'(1);
  endfunction

  assign rd_req   = browse_next | browse_prev | scan_tick;
  assign rd_dir   = (browse_next || !browse_prev) ? DIR_NEXT : DIR_PREV;
  assign wr_start = (state_q == IDLE) && (cal_done || pend_wr);
  assign scan_en  = auto_en && (count != '0);
  assign scan_clr = wr_start | browse_next | browse_prev;

  dwell_timer #(.DWELL_CYCLES(DWELL_CYCLES)) u_dwell (
    .clk  (clk),
    .rst  (rst),
    .en   (scan_en),
    .clr  (scan_clr),
    .tick (scan_tick)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= '0;
      display      <= '0;
      disp_addr    <= '0;
      pend_wr      <= 1'b0;
      pend_rd      <= 1'b0;
      pend_dir     <= DIR_NEXT;
      pend_data    <= '0;
      ram.ram_en   <= 1'b0;
      ram.ram_we   <= 1'b0;
      ram.ram_addr <= '0;
      ram.ram_din  <= '0;
      busy         <= 1'b0;
    end else begin
      state_q      <= state_d;
      wr_ptr       <= wr_ptr_d;
      rd_ptr       <= rd_ptr_d;
      count        <= count_d;
      display      <= display_d;
      disp_addr    <= disp_addr_d;
      pend_wr      <= pend_wr_d;
      pend_rd      <= pend_rd_d;
      pend_dir     <= pend_dir_d;
      pend_data    <= pend_data_d;
      ram.ram_en   <= ram_en_d;
      ram.ram_we   <= ram_we_d;
      ram.ram_addr <= ram_addr_d;
      ram.ram_din  <= ram_din_d;
      busy         <= busy_d;
    end
  end

  // RAM strobes are computed for the state being entered so they leave a flop.
  always_comb begin
    state_d     = state_q;
    wr_ptr_d    = wr_ptr;
    rd_ptr_d    = rd_ptr;
    count_d     = count;
    display_d   = display;
    disp_addr_d = disp_addr;
    pend_wr_d   = pend_wr;
    pend_rd_d   = pend_rd;
    pend_dir_d  = pend_dir;
    pend_data_d = pend_data;
    ram_en_d    = 1'b0;
    ram_we_d    = 1'b0;
    ram_addr_d  = ram.ram_addr;
    ram_din_d   = ram.ram_din;

    unique case (state_q)
      IDLE: begin
        if (wr_start) begin
          state_d    = WRITE;
          ram_en_d   = 1'b1;
          ram_we_d   = 1'b1;
          ram_addr_d = wr_ptr;
          ram_din_d  = pend_wr ? pend_data : cal_result;
          pend_wr_d  = pend_wr && cal_done;
          if (pend_wr && cal_done) pend_data_d = cal_result;
          if (rd_req && !pend_rd) begin
            pend_rd_d  = 1'b1;
            pend_dir_d = rd_dir;
          end
        end else if (pend_rd || rd_req) begin
          pend_rd_d = 1'b0;
          if (count != '0) begin
            state_d    = READ;
            ram_en_d   = 1'b1;
            ram_addr_d = step_addr(rd_ptr, count, pend_rd ? pend_dir : rd_dir);
          end
        end
      end
      WRITE: begin
        state_d     = IDLE;
        display_d   = ram.ram_din;
        disp_addr_d = ram.ram_addr;
        rd_ptr_d    = ram.ram_addr;
        wr_ptr_d    = wr_ptr + ADDR_W'(1);
        if (count != FULL) count_d = count + (ADDR_W+1)'(1);
      end
      READ: state_d = WAIT;
      WAIT: begin
        state_d     = IDLE;
        display_d   = ram.ram_dout;
        disp_addr_d = ram.ram_addr;
        rd_ptr_d    = ram.ram_addr;
      end
    endcase

    if (state_q != IDLE) begin
      if (cal_done) begin
        pend_wr_d   = 1'b1;
        pend_data_d = cal_result;
      end
      if (rd_req && !pend_rd) begin
        pend_rd_d  = 1'b1;
        pend_dir_d = rd_dir;
      end
    end

    busy_d = (state_d != IDLE);
  end
endmodule

// File: tb/tb_result_display_scheduler.sv
// Directed + randomized bench for result_display_scheduler with a transaction-level ring model.
module tb_result_display_scheduler;
  localparam int AW = 4;
  localparam int DW = 8;
  localparam int DWELL = 8;
  localparam int DEPTH = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          cal_done = 1'b0;
  logic [DW-1:0] cal_result = '0;
  logic          browse_next = 1'b0;
  logic          browse_prev = 1'b0;
  logic          auto_en = 1'b0;
  logic [DW-1:0] display;
  logic [AW-1:0] disp_addr;
  logic [AW:0]   count;
  logic          busy;

  int total = 0;
  int passed = 0;
  int failed = 0;
  int cyc = 0;

  result_display_scheduler_if #(.ADDR_W(AW), .DATA_W(DW)) ram_if ();

  result_display_scheduler #(.ADDR_W(AW), .DATA_W(DW), .DWELL_CYCLES(DWELL)) dut (
    .clk         (clk),
    .rst         (rst),
    .cal_done    (cal_done),
    .cal_result  (cal_result),
    .browse_next (browse_next),
    .browse_prev (browse_prev),
    .auto_en     (auto_en),
    .ram         (ram_if),
    .display     (display),
    .disp_addr   (disp_addr),
    .count       (count),
    .busy        (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Synchronous single-port RAM with one-cycle read latency.
  logic [DW-1:0] mem [DEPTH];
  always @(posedge clk) begin
    if (ram_if.ram_en) begin
      if (ram_if.ram_we) mem[ram_if.ram_addr] <= ram_if.ram_din;
      else               ram_if.ram_dout <= mem[ram_if.ram_addr];
    end
  end

  // Reference model: ring contents, window size and pointers as plain integers.
  logic [DW-1:0] ref_mem [DEPTH];
  logic [DW-1:0] ref_disp;
  int ref_count, ref_wr, ref_rd, ref_daddr;

  function automatic void model_reset();
    ref_count = 0; ref_wr = 0; ref_rd = 0; ref_daddr = 0; ref_disp = '0;
  endfunction

  function automatic void model_write(input logic [DW-1:0] v);
    ref_mem[ref_wr] = v;
    ref_disp  = v;
    ref_daddr = ref_wr;
    ref_rd    = ref_wr;
    ref_wr    = (ref_wr + 1) % DEPTH;
    if (ref_count < DEPTH) ref_count++;
  endfunction

  function automatic int model_target(input bit nxt);
    int n;
    n = ref_count;
    return nxt ? (ref_rd + 1) % n : (ref_rd + n - 1) % n;
  endfunction

  function automatic void model_read(input int tgt);
    ref_rd = tgt; ref_daddr = tgt; ref_disp = ref_mem[tgt];
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc1();
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cyc1(); cyc1();
    rst = 1'b0;
    model_reset();
  endtask

  task automatic check_shown(input string tag);
    check({tag, "_disp"}, 32'(display), 32'(ref_disp));
    check({tag, "_daddr"}, 32'(disp_addr), 32'(ref_daddr));
    check({tag, "_count"}, 32'(count), 32'(ref_count));
  endtask

  task automatic do_write(input logic [DW-1:0] v, input bit chk_bus);
    cal_done = 1'b1; cal_result = v;
    cyc1();
    cal_done = 1'b0;
    if (chk_bus) begin
      check("wr_en", 32'(ram_if.ram_en), 32'(1));
      check("wr_we", 32'(ram_if.ram_we), 32'(1));
      check("wr_addr", 32'(ram_if.ram_addr), 32'(ref_wr));
      check("wr_din", 32'(ram_if.ram_din), 32'(v));
      check("wr_busy", 32'(busy), 32'(1));
    end
    cyc1();
    model_write(v);
    check_shown("wr");
  endtask

  task automatic do_browse(input bit nxt);
    int tgt;
    if (nxt) browse_next = 1'b1; else browse_prev = 1'b1;
    cyc1();
    browse_next = 1'b0; browse_prev = 1'b0;
    if (ref_count == 0) begin
      check("drop_en", 32'(ram_if.ram_en), 32'(0));
      check("drop_busy", 32'(busy), 32'(0));
      cyc1(); cyc1();
      check("drop_disp", 32'(display), 32'(ref_disp));
    end else begin
      tgt = model_target(nxt);
      check("rd_en", 32'(ram_if.ram_en), 32'(1));
      check("rd_we", 32'(ram_if.ram_we), 32'(0));
      check("rd_addr", 32'(ram_if.ram_addr), 32'(tgt));
      cyc1();
      check("rd_wait_en", 32'(ram_if.ram_en), 32'(0));
      cyc1();
      model_read(tgt);
      check_shown("rd");
    end
  endtask

  initial begin
    int tgt, prev_addr, last_cyc, waited, r;
    model_reset();
    do_reset();
    check("rst_disp", 32'(display), 32'(0));
    check("rst_daddr", 32'(disp_addr), 32'(0));
    check("rst_count", 32'(count), 32'(0));
    check("rst_busy", 32'(busy), 32'(0));
    check("rst_en", 32'(ram_if.ram_en), 32'(0));

    do_write(8'hA5, 1'b1);

    do_reset();
    do_write(8'h11, 1'b1);
    do_write(8'h22, 1'b1);
    do_write(8'h33, 1'b1);
    do_browse(1'b1);
    check("next_0x11", 32'(display), 32'(8'h11));
    do_browse(1'b0);
    check("prev_0x33", 32'(display), 32'(8'h33));

    // Write and read requested together: write first, read served afterwards.
    cal_done = 1'b1; cal_result = 8'h44; browse_next = 1'b1;
    cyc1();
    cal_done = 1'b0; browse_next = 1'b0;
    check("cmb_we", 32'(ram_if.ram_we), 32'(1));
    check("cmb_waddr", 32'(ram_if.ram_addr), 32'(3));
    cyc1();
    model_write(8'h44);
    check_shown("cmb_wr");
    cyc1();
    tgt = model_target(1'b1);
    check("cmb_ren", 32'(ram_if.ram_en), 32'(1));
    check("cmb_rwe", 32'(ram_if.ram_we), 32'(0));
    check("cmb_raddr", 32'(ram_if.ram_addr), 32'(tgt));
    cyc1(); cyc1();
    model_read(tgt);
    check_shown("cmb_rd");
    check("cmb_0x11", 32'(display), 32'(8'h11));

    do_reset();
    do_browse(1'b1);
    check("empty_disp", 32'(display), 32'(0));

    for (int i = 0; i < 17; i++) do_write(8'(i), 1'b0);
    check("full_count", 32'(count), 32'(DEPTH));
    check("full_disp", 32'(display), 32'(8'h10));
    check("full_daddr", 32'(disp_addr), 32'(0));
    do_browse(1'b1);
    check("full_next", 32'(display), 32'(8'h01));
    do_browse(1'b0);
    do_browse(1'b0);

    // Result arriving during a read is held and written once the read finishes.
    browse_next = 1'b1;
    cyc1();
    browse_next = 1'b0;
    tgt = model_target(1'b1);
    check("pw_raddr", 32'(ram_if.ram_addr), 32'(tgt));
    cal_done = 1'b1; cal_result = 8'h5A;
    cyc1();
    cal_done = 1'b0;
    cyc1();
    model_read(tgt);
    check_shown("pw_rd");
    cyc1(); cyc1();
    model_write(8'h5A);
    check_shown("pw_wr");

    do_reset();
    repeat (60) begin
      r = $urandom_range(0, 9);
      if (r < 4) do_write(8'($urandom), 1'b1);
      else       do_browse(r[0]);
      repeat ($urandom_range(0, 2)) cyc1();
    end

    do_reset();
    for (int i = 0; i < 3; i++) do_write(8'($urandom), 1'b0);
    auto_en = 1'b1;
    prev_addr = int'(disp_addr);
    last_cyc = cyc;
    for (int k = 0; k < 4; k++) begin
      waited = 0;
      while (int'(disp_addr) == prev_addr && waited < 40) begin
        cyc1();
        waited++;
      end
      check("auto_timeout", 32'(waited < 40), 32'(1));
      tgt = model_target(1'b1);
      model_read(tgt);
      check("auto_daddr", 32'(disp_addr), 32'(ref_daddr));
      check("auto_disp", 32'(display), 32'(ref_disp));
      if (k > 0) check("auto_period", 32'(cyc - last_cyc), 32'(DWELL));
      last_cyc = cyc;
      prev_addr = int'(disp_addr);
    end
    auto_en = 1'b0;
    cyc1(); cyc1(); cyc1();

    // Reset asserted while a read is in flight.
    browse_next = 1'b1;
    cyc1();
    browse_next = 1'b0;
    check("mid_en", 32'(ram_if.ram_en), 32'(1));
    rst = 1'b1;
    #1;
    check("mid_disp", 32'(display), 32'(0));
    check("mid_count", 32'(count), 32'(0));
    check("mid_en0", 32'(ram_if.ram_en), 32'(0));
    check("mid_busy", 32'(busy), 32'(0));
    cyc1();
    rst = 1'b0;
    model_reset();
    cyc1(); cyc1();
    check("post_busy", 32'(busy), 32'(0));
    do_write(8'h3C, 1'b1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not complete, %0d/%0d checks passed", passed, total);
    $fatal(1);
  end
endmodule
